edge_det_filt: RTL and testbench

- Multi-channel edge detector, parametrised successor to the single-bit edge detector; default 3 channels for the A/B/Z encoder lines.
- Per channel: N-flop input synchroniser, then a stable-count glitch filter, then registered single-cycle POS/NEG/ANY pulses and a filtered level output.
- Per channel GLITCH pulse flags aborted transitions for encoder signal-quality diagnostics.
- Sits between the raw encoder pins and the quadrature decoder / index logic.

---
 rtl/edge_det_filt_if.sv | 15 +
 rtl/edge_det_filt.sv | 77 +++++++
 tb/tb_edge_det_filt.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/edge_det_filt_if.sv
// rtl/edge_det_filt_if.sv - enable, raw inputs and filtered level/pulse outputs of edge_det_filt
interface edge_det_filt_if #(
    parameter int WIDTH = 3
);
  logic             EN;
  logic [WIDTH-1:0] IN;
  logic [WIDTH-1:0] LEVEL;
  logic [WIDTH-1:0] POS;
  logic [WIDTH-1:0] NEG;
  logic [WIDTH-1:0] ANY;
  logic [WIDTH-1:0] GLITCH;

  modport master (output EN, IN, input LEVEL, POS, NEG, ANY, GLITCH);
  modport slave  (input EN, IN, output LEVEL, POS, NEG, ANY, GLITCH);
endinterface

// File: rtl/edge_det_filt.sv
// rtl/edge_det_filt.sv - multi-channel synchronised, glitch-filtered edge detector
// Each channel: SYNC_STAGES-flop synchroniser, stable-count filter, registered pulses.
module edge_det_filt #(
    parameter int WIDTH       = 3,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CNT    = 4,
    parameter bit INIT_LEVEL  = 1'b0
) (
    input  logic          CLK,
    input  logic          ARSTN,
    edge_det_filt_if.slave bus
);
  localparam int CW = $clog2(FILT_CNT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CNT - 1);

  logic [SYNC_STAGES-1:0] sync_q [WIDTH];
  logic [CW-1:0]          cnt_q  [WIDTH];
  logic [WIDTH-1:0]       s;
  logic [WIDTH-1:0]       level_q;
  logic [WIDTH-1:0]       pos_q;
  logic [WIDTH-1:0]       neg_q;
  logic [WIDTH-1:0]       any_q;
  logic [WIDTH-1:0]       glitch_q;

  always_comb begin
    s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      s[i] = sync_q[i][SYNC_STAGES-1];
    end
  end

  always_ff @(posedge CLK or negedge ARSTN) begin
    if (!ARSTN) begin
      for (int i = 0; i < WIDTH; i++) begin
        sync_q[i] <= {SYNC_STAGES{INIT_LEVEL}};
        cnt_q[i]  <= '0;
      end
      level_q  <= {WIDTH{INIT_LEVEL}};
      pos_q    <= '0;
      neg_q    <= '0;
      any_q    <= '0;
      glitch_q <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        // The synchroniser keeps running while the filter is disabled
        sync_q[i] <= SYNC_STAGES'({sync_q[i], bus.IN[i]});
        pos_q[i]    <= 1'b0;
        neg_q[i]    <= 1'b0;
        any_q[i]    <= 1'b0;
        glitch_q[i] <= 1'b0;
        if (!bus.EN) begin
          cnt_q[i] <= '0;
        end else if (s[i] != level_q[i]) begin
          if (cnt_q[i] == CNT_LAST) begin
            level_q[i] <= s[i];
            cnt_q[i]   <= '0;
            pos_q[i]   <= s[i];
            neg_q[i]   <= ~s[i];
            any_q[i]   <= 1'b1;
          end else begin
            cnt_q[i] <= cnt_q[i] + CW'(1);
          end
        end else if (cnt_q[i] != '0) begin
          // Input returned to LEVEL before the count completed
          cnt_q[i]    <= '0;
          glitch_q[i] <= 1'b1;
        end
      end
    end
  end

  assign bus.LEVEL  = level_q;
  assign bus.POS    = pos_q;
  assign bus.NEG    = neg_q;
  assign bus.ANY    = any_q;
  assign bus.GLITCH = glitch_q;
endmodule

// File: tb/tb_edge_det_filt.sv
// tb/tb_edge_det_filt.sv - scoreboard bench for edge_det_filt in two configurations
module tb_edge_det_filt;
  localparam int W = 3;

  logic CLK = 1'b0;
  logic ARSTN = 1'b0;
  logic en_d = 1'b1;
  logic [W-1:0] in_d = '0;
  always #5 CLK = ~CLK;

  edge_det_filt_if #(.WIDTH(W)) ifa ();
  edge_det_filt_if #(.WIDTH(W)) ifb ();
  assign ifa.EN = en_d;
  assign ifa.IN = in_d;
  assign ifb.EN = en_d;
  assign ifb.IN = in_d;

  edge_det_filt #(.WIDTH(W), .SYNC_STAGES(2), .FILT_CNT(4), .INIT_LEVEL(1'b0)) dut_a (
      .CLK(CLK), .ARSTN(ARSTN), .bus(ifa.slave));
  edge_det_filt #(.WIDTH(W), .SYNC_STAGES(3), .FILT_CNT(1), .INIT_LEVEL(1'b1)) dut_b (
      .CLK(CLK), .ARSTN(ARSTN), .bus(ifb.slave));

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%b required=%b t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: s is the input seen SYNC_STAGES edges ago; LEVEL follows s once
  // s has differed from LEVEL on FILT_CNT consecutive enabled edges.
  int       S_C [2] = '{2, 3};
  int       F_C [2] = '{4, 1};
  bit       I_C [2] = '{1'b0, 1'b1};
  logic [W-1:0] sh [2][3];
  logic [W-1:0] lvl [2];
  int       since [2][W];
  int       n = 0;

  typedef struct packed {
    logic [5*W-1:0] a;
    logic [5*W-1:0] b;
  } exp_t;
  exp_t eq[$];

  function automatic void model_reset();
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < 3; k++) sh[c][k] = {W{I_C[c]}};
      lvl[c] = {W{I_C[c]}};
      for (int ch = 0; ch < W; ch++) since[c][ch] = -1;
    end
    eq.delete();
  endfunction

  function automatic logic [5*W-1:0] model_edge(input int c);
    logic [W-1:0] s, pos, neg, any, gl;
    s = sh[c][S_C[c]-1];
    for (int k = 2; k > 0; k--) sh[c][k] = sh[c][k-1];
    sh[c][0] = in_d;
    pos = '0; neg = '0; any = '0; gl = '0;
    for (int ch = 0; ch < W; ch++) begin
      if (!en_d) begin
        since[c][ch] = -1;
      end else if (s[ch] != lvl[c][ch]) begin
        if (since[c][ch] < 0) since[c][ch] = n;
        if (n - since[c][ch] + 1 >= F_C[c]) begin
          lvl[c][ch] = s[ch];
          pos[ch] = s[ch];
          neg[ch] = ~s[ch];
          any[ch] = 1'b1;
          since[c][ch] = -1;
        end
      end else begin
        gl[ch] = (since[c][ch] >= 0);
        since[c][ch] = -1;
      end
    end
    return {lvl[c], pos, neg, any, gl};
  endfunction

  always @(posedge CLK) begin
    exp_t e;
    if (ARSTN) begin
      n++;
      e.a = model_edge(0);
      e.b = model_edge(1);
      eq.push_back(e);
    end
  end

  task automatic cmp(input string p, input logic [5*W-1:0] act, input logic [5*W-1:0] exp);
    chk({p, ".LEVEL"},  act[5*W-1:4*W], exp[5*W-1:4*W]);
    chk({p, ".POS"},    act[4*W-1:3*W], exp[4*W-1:3*W]);
    chk({p, ".NEG"},    act[3*W-1:2*W], exp[3*W-1:2*W]);
    chk({p, ".ANY"},    act[2*W-1:W],   exp[2*W-1:W]);
    chk({p, ".GLITCH"}, act[W-1:0],     exp[W-1:0]);
  endtask

  always @(posedge CLK) begin
    exp_t e;
    #1;
    if (ARSTN && eq.size() > 0) begin
      e = eq.pop_front();
      cmp("A", {ifa.LEVEL, ifa.POS, ifa.NEG, ifa.ANY, ifa.GLITCH}, e.a);
      cmp("B", {ifb.LEVEL, ifb.POS, ifb.NEG, ifb.ANY, ifb.GLITCH}, e.b);
    end
  end

  task automatic drive(input logic [W-1:0] i, input logic e);
    @(negedge CLK);
    in_d = i;
    en_d = e;
  endtask

  task automatic idle(input int k);
    repeat (k) @(posedge CLK);
  endtask

  // Edges until the selected pulse appears on dut A (which=0) or B (which=1); -1 on timeout
  task automatic measure(input int which, input int neg_sel, input int b, output int cyc);
    logic [W-1:0] v;
    cyc = -1;
    for (int i = 1; i <= 30; i++) begin
      @(posedge CLK);
      #1;
      if (which == 0) v = neg_sel ? ifa.NEG : ifa.POS;
      else            v = neg_sel ? ifb.NEG : ifb.POS;
      if (v[b]) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    ARSTN = 1'b0;
    #1;
    model_reset();
    chk("rst.A.LEVEL", ifa.LEVEL, 3'b000);
    chk("rst.A.PULSES", ifa.POS | ifa.NEG | ifa.ANY | ifa.GLITCH, 3'b000);
    chk("rst.B.LEVEL", ifb.LEVEL, 3'b111);
    chk("rst.B.PULSES", ifb.POS | ifb.NEG | ifb.ANY | ifb.GLITCH, 3'b000);
    idle(2);
    @(negedge CLK);
    ARSTN = 1'b1;
  endtask

  initial begin
    int cyc;
    logic [W-1:0] r;
    model_reset();
    do_reset();
    idle(20);

    drive(3'b001, 1'b1);
    measure(0, 0, 0, cyc);
    chk("lat.A.POS0", 3'(cyc), 3'd6);
    idle(4);
    drive(3'b000, 1'b1);
    measure(0, 1, 0, cyc);
    chk("lat.A.NEG0", 3'(cyc), 3'd6);
    idle(8);

    drive(3'b010, 1'b1);
    idle(3);
    drive(3'b000, 1'b1);
    idle(10);

    drive(3'b111, 1'b1);
    idle(10);
    drive(3'b110, 1'b1);
    measure(1, 1, 0, cyc);
    chk("lat.B.NEG0", 3'(cyc), 3'd4);
    idle(8);
    drive(3'b000, 1'b1);
    idle(10);

    drive(3'b100, 1'b1);
    idle(4);
    drive(3'b100, 1'b0);
    idle(5);
    drive(3'b100, 1'b1);
    measure(0, 0, 2, cyc);
    chk("en.A.POS2", 3'(cyc), 3'd4);
    idle(8);

    r = '0;
    repeat (2000) begin
      @(negedge CLK);
      for (int ch = 0; ch < W; ch++)
        if ($urandom_range(5) == 0) r[ch] = ~r[ch];
      in_d = r;
      en_d = ($urandom_range(19) != 0);
    end

    drive(3'b111, 1'b1);
    idle(10);
    drive(3'b000, 1'b1);
    idle(4);
    do_reset();
    idle(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
